// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide unit for a MIPS-style EX stage: one-cycle multiply,
// restoring divide (one quotient bit per cycle), MTHI/MTLO and pipeline stall control.
module muldiv_ctrl #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(DIV_ITER + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic          r_signed;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [31:0]   r_quo;
    logic [31:0]   r_rem;
    logic [31:0]   r_dvs;
    logic [CW-1:0] r_cnt;

    logic          w_is_mul;
    logic          w_is_div;
    logic          w_op_signed;
    logic          w_accept;
    logic          w_load;
    logic          w_div_last;
    logic [31:0]   w_a_abs;
    logic [31:0]   w_b_abs;
    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic [63:0]   w_prod;
    logic [32:0]   w_shift;
    logic          w_ge;
    logic [31:0]   w_rem_next;
    logic [31:0]   w_quo_next;
    logic [31:0]   w_div_hi;
    logic [31:0]   w_div_lo;
    logic          w_hi_we;
    logic          w_lo_we;
    logic [31:0]   w_hi_d;
    logic [31:0]   w_lo_d;

    assign w_is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_accept    = (r_state == S_IDLE) && start && !flush;
    assign w_load      = w_accept && (w_is_mul || (w_is_div && (b != 32'd0)));
    assign w_div_last  = (r_cnt == CW'(DIV_ITER - 1));

    // Divide runs on magnitudes; signs are reapplied when the result is written.
    assign w_a_abs = (w_op_signed && a[31]) ? (32'd0 - a) : a;
    assign w_b_abs = (w_op_signed && b[31]) ? (32'd0 - b) : b;

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod   = r_signed ? w_prod_s : w_prod_u;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[31:0] - r_dvs) : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};
    assign w_div_lo   = r_neg_q ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_div_hi   = r_neg_r ? (32'd0 - w_rem_next) : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_is_mul) begin
                        w_next_state = S_MUL;
                    end else if (start && w_is_div) begin
                        w_next_state = (b != 32'd0) ? S_DIV : S_DONE;
                    end
                end
                S_MUL:  w_next_state = S_DONE;
                S_DIV:  w_next_state = w_div_last ? S_DONE : S_DIV;
                S_DONE: w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Write sources are mutually exclusive by state, so the order below is only a tie-break.
    always_comb begin
        w_hi_we = 1'b0;
        w_lo_we = 1'b0;
        w_hi_d  = hi;
        w_lo_d  = lo;
        if (w_accept && (op == OP_MTHI)) begin
            w_hi_we = 1'b1;
            w_hi_d  = a;
        end else if (w_accept && (op == OP_MTLO)) begin
            w_lo_we = 1'b1;
            w_lo_d  = a;
        end else if ((r_state == S_MUL) && !flush) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = w_prod[63:32];
            w_lo_d  = w_prod[31:0];
        end else if ((r_state == S_DIV) && !flush && w_div_last) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = w_div_hi;
            w_lo_d  = w_div_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            if (w_hi_we) hi <= w_hi_d;
            if (w_lo_we) lo <= w_lo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
        end else if (flush) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
        end else if (w_load) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= w_op_signed;
            r_neg_q  <= w_op_signed && (a[31] != b[31]);
            r_neg_r  <= w_op_signed && a[31];
            r_quo    <= w_a_abs;
            r_rem    <= 32'd0;
            r_dvs    <= w_b_abs;
        end else if (r_state == S_DIV) begin
            r_quo    <= w_quo_next;
            r_rem    <= w_rem_next;
        end
    end

    // Counter holds at zero outside DIV and never counts past DIV_ITER-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_DIV) && !flush && !w_div_last) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign stall     = !rst && !flush &&
                       (((r_state == S_IDLE) && start && (w_is_mul || w_is_div)) || busy);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and randomized checks of muldiv_ctrl against an arithmetic HI/LO model.
module tb_muldiv_ctrl;

    localparam int DIV_ITER = 32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.DIV_ITER(DIV_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result of an op on HI/LO, from plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        res = {h, l};
        case (o)
            3'd1: res = 64'(sx * sy);
            3'd2: res = ux * uy;
            3'd3: if (y != 32'd0) begin
                sq  = sx / sy;
                sr  = sx % sy;
                res = {sr[31:0], sq[31:0]};
            end
            3'd4: if (y != 32'd0) begin
                res = {32'(ux % uy), 32'(ux / uy)};
            end
            3'd5: res = {x, l};
            3'd6: res = {h, x};
            default: res = {h, l};
        endcase
        return res;
    endfunction

    function automatic int exp_stall(input logic [2:0] o, input logic [31:0] y);
        if (o == 3'd1 || o == 3'd2) return 2;
        if (o == 3'd3 || o == 3'd4) return (y == 32'd0) ? 1 : DIV_ITER + 1;
        return 0;
    endfunction

    // Issue one EX-stage op, hold it while stalled, retire it, count stall cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        int          ncyc;
        logic        ok;
        logic [63:0] e;
        exp_q.push_back(model(o, x, y, m_hi, m_lo));
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        ncyc  = 0;
        ok    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!stall) begin
                ok = 1'b1;
                break;
            end
            ncyc++;
            @(negedge clk);
        end
        check({tag, "_done"}, 64'(ok), 64'd1);
        check({tag, "_stall_cycles"}, 64'(ncyc), 64'(exp_stall(o, y)));
        check({tag, "_busy_at_retire"}, 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        e     = exp_q.pop_front();
        {m_hi, m_lo} = e;
        #1;
        check({tag, "_hilo"}, {hi, lo}, e);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] keep_hi;
        logic [31:0] keep_lo;
        n_checks = 0;
        n_fail   = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        rst      = 1'b1;
        start    = 1'b1;
        op       = 3'd1;
        a        = 32'd3;
        b        = 32'd4;
        flush    = 1'b0;

        // Reset state, with a mul request present to show stall is held low.
        #12;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'd0;

        run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5);
        check("mult_neg_value", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run_op("divu_100_7", 3'd4, 32'd100, 32'd7);
        check("divu_100_7_value", {hi, lo}, {32'd2, 32'd14});
        run_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2);
        check("div_m7_2_value", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op("mthi", 3'd5, 32'h1234, 32'd0);
        run_op("mtlo", 3'd6, 32'h5678, 32'd0);
        run_op("div_by_zero", 3'd3, 32'd99, 32'd0);
        check("div_by_zero_value", {hi, lo}, {32'h1234, 32'h5678});
        run_op("divu_by_zero", 3'd4, 32'd5, 32'd0);

        // Flush on the 10th DIV cycle of a DIVU.
        keep_hi = hi;
        keep_lo = lo;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall_low", 64'(stall), 64'd0);
        check("flush_busy_before", 64'(busy), 64'd1);
        start = 1'b0;
        op    = 3'd0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_hilo_kept", {hi, lo}, {keep_hi, keep_lo});
        run_op("mtlo_after_flush", 3'd6, 32'hA5, 32'd0);
        check("mtlo_after_flush_value", 64'(lo), 64'hA5);

        // Flushed MTHI must not write; flushed MULT must not stall.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEAD;
        flush = 1'b1;
        #1;
        check("flush_mthi_stall", 64'(stall), 64'd0);
        @(negedge clk);
        op    = 3'd1;
        #1;
        check("flush_mult_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        flush = 1'b0;
        #1;
        check("flush_mthi_hilo", {hi, lo}, {m_hi, m_lo});
        check("flush_mult_busy", 64'(busy), 64'd0);

        // Reset pulsed while MULTU is in MUL.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        a     = 32'h77;
        b     = 32'h88;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        run_op("multu_after_rst", 3'd2, 32'hFFFFFFFF, 32'd2);
        check("multu_after_rst_value", {hi, lo}, {32'd1, 32'hFFFFFFFE});

        // Randomized ops against the model.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = 32'd0 - 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if (ro == 3'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            run_op("rand", ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter DIV_ITER, default 32, the number of restoring-division iterations (one quotient bit per cycle).
REQ-002 SHALL have port clk, input, 1, the sole clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, EX-stage instruction valid with a mul/div/move-to-HILO op.
REQ-005 SHALL have port op, input, 3, operation: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-op.
REQ-006 SHALL have port a, input, 32, rs operand.
REQ-007 SHALL have port b, input, 32, rt operand.
REQ-008 SHALL have port flush, input, 1, exception/pipeline flush that cancels any in-flight op.
REQ-009 SHALL have port stall, output, 1, pipeline stall request (combinational).
REQ-010 SHALL have port busy, output, 1, high when the FSM is in MUL or DIV.
REQ-011 SHALL have port hi, output, 32, registered HI register.
REQ-012 SHALL have port lo, output, 32, registered LO register.

Function
REQ-013 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE, with start=1, flush=0, op in {1,2}: SHALL latch operands and go to MUL.
REQ-015 In IDLE, with start=1, flush=0, op in {3,4} and b!=0: SHALL latch operands and go to DIV with iteration counter=0.
REQ-016 In IDLE, with start=1, flush=0, op in {3,4} and b==0: SHALL go directly to DONE and leave HI/LO unchanged.
REQ-017 In IDLE, with start=1, flush=0, op=5 (MTHI): SHALL write hi=a at that edge, with no stall and no state change.
REQ-018 In IDLE, with start=1, flush=0, op=6 (MTLO): SHALL write lo=a at that edge, with no stall and no state change.
REQ-019 MUL: SHALL compute the 64-bit product (signed for op 1, unsigned for op 2), write {hi,lo} at the edge leaving MUL, and go to DONE.
REQ-020 DIV: SHALL perform one restoring iteration per cycle on the absolute values; after DIV_ITER iterations SHALL write lo=quotient and hi=remainder, then go to DONE.
REQ-021 Signed DIV SHALL negate the quotient when sign(a)!=sign(b) and give the remainder the sign of a; DIVU SHALL treat both operands as unsigned.
REQ-022 DONE: SHALL keep stall=0, ignore start, and go to IDLE on the next edge (the held EX instruction retires).
REQ-023 SHALL drive stall = ~flush & ((state==IDLE & start & op in {1..4}) | state==MUL | state==DIV).
REQ-024 Stall lengths SHALL be: 2 stall cycles for MULT/MULTU, DIV_ITER+1 for DIV/DIVU with b!=0, and 1 for a divide by zero.
REQ-025 flush=1 in any state SHALL force the state to IDLE at the next edge, abort any pending HI/LO write, and discard the latched operands.
REQ-026 flush=1 together with an MTHI/MTLO start SHALL suppress that write.
REQ-027 SHALL give the results registers a precedence of HI/LO writes over hold; only one write source can be active per cycle by construction.
REQ-028 The iteration counter SHALL be ceil(log2(DIV_ITER+1)) bits wide and SHALL NOT wrap; the transition occurs when the count equals DIV_ITER-1.

Reset
REQ-029 While rst=1, asynchronously: SHALL force state=IDLE, hi=0, lo=0, counter=0, busy=0, and stall=0.
REQ-030 Reset asserted mid-MUL/DIV SHALL abandon the op; after release the block SHALL be in IDLE, accepting start on the first edge.

Verification
REQ-031 MULT a=0xFFFFFFFD (-3), b=5 -> stall high exactly 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 DIVU a=100, b=7 -> stall high 33 cycles; lo=14, hi=2; busy low in DONE.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIV with b=0 and hi=0x1234, lo=0x5678 beforehand -> stall high 1 cycle; hi/lo unchanged.
REQ-035 DIVU started, flush at 10th DIV cycle -> stall low that cycle, IDLE next edge, hi/lo unchanged; a following MTLO a=0xA5 writes lo=0xA5 with no stall.
REQ-036 rst pulsed mid-MULTU -> hi=lo=0, stall=0 immediately; a MULTU a=0xFFFFFFFF, b=2 after release -> hi=1, lo=0xFFFFFFFE.
